// File: rtl/key_event_repeat.sv
`default_nettype none
// ============================================================================
// key_event_repeat : press/release pulses plus typematic auto-repeat for a key
// Rev 1.0
// ============================================================================
module key_event_repeat #(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int CNT_W        = 16,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    input  logic       tick_en,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       repeat_pulse,
    output logic       key_pulse,
    output logic       held,
    output logic [7:0] rep_count
);

    localparam logic [CNT_W-1:0] c_HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] c_REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [7:0]       w_rep_n;
    logic             w_press_n, w_release_n, w_repeat_n;
    logic             w_act;
    logic [7:0]       w_rep_inc;

    assign w_act     = ACTIVE_LOW ? ~key_in : key_in;
    assign w_rep_inc = (rep_count == 8'hFF) ? rep_count : rep_count + 8'd1;

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_rep_n     = rep_count;
        w_press_n   = 1'b0;
        w_release_n = 1'b0;
        w_repeat_n  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_act) begin
                    w_state_n = HOLD;
                    w_press_n = 1'b1;
                    w_cnt_n   = '0;
                    w_rep_n   = 8'd0;
                end
            end
            HOLD, REPEAT: begin
                // Release wins over a repeat falling due on the same edge.
                if (!w_act) begin
                    w_state_n   = IDLE;
                    w_release_n = 1'b1;
                    w_cnt_n     = '0;
                end else if (tick_en) begin
                    if (r_cnt == ((r_state == HOLD) ? c_HOLD_LAST : c_REPEAT_LAST)) begin
                        w_state_n  = REPEAT;
                        w_cnt_n    = '0;
                        w_repeat_n = 1'b1;
                        w_rep_n    = w_rep_inc;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            key_pulse     <= 1'b0;
            held          <= 1'b0;
            rep_count     <= 8'd0;
        end else begin
            r_state       <= w_state_n;
            r_cnt         <= w_cnt_n;
            press_pulse   <= w_press_n;
            release_pulse <= w_release_n;
            repeat_pulse  <= w_repeat_n;
            key_pulse     <= w_press_n | w_repeat_n;
            held          <= (w_state_n != IDLE);
            rep_count     <= w_rep_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_event_repeat.sv
`default_nettype none
// ============================================================================
// tb_key_event_repeat : randomized and directed checks against a tick-count model
// Rev 1.0
// ============================================================================
module tb_key_event_repeat;

    localparam int c_HOLD = 4;
    localparam int c_REP  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_in = 1'b1;
    logic       tick_en = 1'b1;
    logic       press_pulse, release_pulse, repeat_pulse, key_pulse, held;
    logic [7:0] rep_count;

    int checks = 0;
    int errors = 0;

    key_event_repeat #(
        .ACTIVE_LOW  (1'b1),
        .CNT_W       (16),
        .HOLD_TICKS  (c_HOLD),
        .REPEAT_TICKS(c_REP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .tick_en      (tick_en),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .key_pulse    (key_pulse),
        .held         (held),
        .rep_count    (rep_count)
    );

    always #5 clk = ~clk;

    // Model: count tick strobes since the press; repeats fall on
    // strobe HOLD, HOLD+REP, HOLD+2*REP, ...
    logic m_pressed = 1'b0;
    int   m_ticks   = 0;
    int   m_reps    = 0;
    logic e_press = 1'b0, e_release = 1'b0, e_repeat = 1'b0;

    function automatic bit due(input int t);
        return (t == c_HOLD) || (t > c_HOLD && ((t - c_HOLD) % c_REP) == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pressed <= 1'b0;
            m_ticks   <= 0;
            m_reps    <= 0;
            e_press   <= 1'b0;
            e_release <= 1'b0;
            e_repeat  <= 1'b0;
        end else begin
            logic act, np, ep, erl, erp;
            int   nt, nr;
            act = ~key_in;
            np = m_pressed; nt = m_ticks; nr = m_reps;
            ep = 1'b0; erl = 1'b0; erp = 1'b0;
            if (!m_pressed) begin
                if (act) begin
                    np = 1'b1; nt = 0; nr = 0; ep = 1'b1;
                end
            end else if (!act) begin
                np = 1'b0; erl = 1'b1;
            end else if (tick_en) begin
                nt = nt + 1;
                if (due(nt)) begin
                    erp = 1'b1;
                    nr  = (nr >= 255) ? 255 : nr + 1;
                end
            end
            m_pressed <= np;
            m_ticks   <= nt;
            m_reps    <= nr;
            e_press   <= ep;
            e_release <= erl;
            e_repeat  <= erp;
        end
    end

    always @(negedge clk) begin
        logic [12:0] got, exp;
        got = {press_pulse, release_pulse, repeat_pulse, key_pulse, held, rep_count};
        exp = {e_press, e_release, e_repeat, e_press | e_repeat, m_pressed, 8'(m_reps)};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL outputs t=%0t got p/r/rp/k/h/cnt=%b expected=%b", $time, got, exp);
        end
    end

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic cyc(input logic k, input logic t);
        key_in  = k;
        tick_en = t;
        @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {press_pulse, release_pulse, repeat_pulse, key_pulse, held}, 0);
        chk("reset_rep_count", rep_count, 0);
        rst = 1'b0;

        // Press, hold through three repeats, release
        cyc(0, 1);
        chk("press_pulse_E", press_pulse, 1);
        chk("held_E", held, 1);
        repeat (3) cyc(0, 1);
        chk("no_repeat_E3", repeat_pulse, 0);
        cyc(0, 1);
        chk("repeat_E4", repeat_pulse, 1);
        chk("rep_count_E4", rep_count, 1);
        repeat (2) cyc(0, 1);
        chk("repeat_E6", repeat_pulse, 1);
        repeat (2) cyc(0, 1);
        chk("rep_count_E8", rep_count, 3);
        cyc(1, 1);
        chk("release_pulse", release_pulse, 1);
        chk("held_after_release", held, 0);
        cyc(1, 1);

        // Short press
        cyc(0, 1);
        cyc(0, 1);
        cyc(1, 1);
        chk("short_release", release_pulse, 1);
        chk("short_rep_count", rep_count, 0);
        cyc(1, 1);

        // Release exactly when the second repeat is due
        cyc(0, 1);
        repeat (5) cyc(0, 1);
        cyc(1, 1);
        chk("release_prio_rel", release_pulse, 1);
        chk("release_prio_rep", repeat_pulse, 0);
        chk("release_prio_cnt", rep_count, 1);
        cyc(1, 1);

        // Sparse tick strobes: one in three
        cyc(0, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(0, (i % 3) == 2);
            chk("sparse_repeat", repeat_pulse, (i == 11) ? 1 : 0);
            chk("sparse_held", held, 1);
        end

        // Reset in REPEAT with key still held
        #2 rst = 1'b1;
        #1 chk("async_clear", {press_pulse, release_pulse, repeat_pulse, key_pulse, held, rep_count}, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        cyc(0, 1);
        chk("press_after_reset", press_pulse, 1);
        repeat (2 * 300 + 10) cyc(0, 1);
        chk("rep_count_saturated", rep_count, 255);
        cyc(1, 1);
        chk("saturated_hold_after_release", rep_count, 255);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            logic k;
            k = ($urandom_range(0, 7) == 0) ? ~key_in : key_in;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
            cyc(k, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
